// File: rtl/note_recorder.sv
// Run-length recorder for the free-play note stream: samples the live note on a
// slow tick into {note,dur} entries and replays them in place of the live note.
module note_recorder #(
  parameter int         DEPTH     = 32,
  parameter int         TICK_DIV  = 10_000_000,
  parameter int         MAX_DUR   = 255,
  parameter logic [2:0] REST_CODE = 3'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 num_note,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  output logic [2:0]                 play_note,
  output logic                       playing,
  output logic                       recording,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     length,
  output logic [1:0]                 fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]    MAX_D     = 8'(MAX_DUR);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    cur_note;
  logic [7:0]    dur;
  logic [AW-1:0] idx;
  logic [7:0]    remain;
  logic [10:0]   mem [DEPTH];

  logic          tick;
  logic          extend;
  logic          rec_we;
  logic [AW:0]   len_inc;
  logic [AW:0]   idx_nxt;
  logic [10:0]   first_entry;
  logic [10:0]   next_entry;

  assign fsm_state = state;

  always_comb begin
    tick        = (cnt == TICK_LAST);
    extend      = (num_note == cur_note) && (dur < MAX_D);
    // A run is only committed when it holds at least one tick.
    rec_we      = (state == REC) && (dur != 8'd0) && (stop || (tick && !extend));
    len_inc     = length + 1'b1;
    idx_nxt     = {1'b0, idx} + 1'b1;
    first_entry = mem[0];
    next_entry  = mem[idx_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rec_we) mem[length[AW-1:0]] <= {cur_note, dur};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_note  <= 3'd0;
      dur       <= 8'd0;
      idx       <= '0;
      remain    <= 8'd0;
      play_note <= REST_CODE;
      playing   <= 1'b0;
      recording <= 1'b0;
      full      <= 1'b0;
      length    <= '0;
    end else begin
      // Idle holds the divider at zero, so each start restarts the tick phase.
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (rec_start) begin
            length    <= '0;
            full      <= 1'b0;
            cur_note  <= num_note;
            dur       <= 8'd0;
            recording <= 1'b1;
            state     <= REC;
          end else if (play_start && length != '0) begin
            idx       <= '0;
            remain    <= first_entry[7:0];
            play_note <= first_entry[10:8];
            playing   <= 1'b1;
            state     <= PLAY;
          end
        end
        REC: begin
          if (stop) begin
            if (rec_we) begin
              length <= len_inc;
              full   <= (len_inc == DEPTH_L);
            end
            recording <= 1'b0;
            state     <= IDLE;
          end else if (tick) begin
            if (extend) begin
              dur <= dur + 8'd1;
            end else begin
              if (rec_we) begin
                length <= len_inc;
                if (len_inc == DEPTH_L) begin
                  full      <= 1'b1;
                  recording <= 1'b0;
                  state     <= IDLE;
                end
              end
              cur_note <= num_note;
              dur      <= 8'd1;
            end
          end
        end
        PLAY: begin
          if (stop) begin
            play_note <= REST_CODE;
            playing   <= 1'b0;
            state     <= IDLE;
          end else if (tick) begin
            if (remain > 8'd1) begin
              remain <= remain - 8'd1;
            end else if (idx_nxt < length) begin
              idx       <= idx_nxt[AW-1:0];
              remain    <= next_entry[7:0];
              play_note <= next_entry[10:8];
            end else begin
              play_note <= REST_CODE;
              playing   <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          playing   <= 1'b0;
          recording <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with a 4-cycle tick; playback is checked by
// collecting runs of play_note against an expected queue of {note, cycles}.
module tb_note_recorder;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] num_note;
  logic       rec_start, play_start, stop;
  logic [2:0] play_note;
  logic       playing, recording, full;
  logic [5:0] length;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  note_recorder #(.DEPTH(32), .TICK_DIV(TD), .MAX_DUR(255), .REST_CODE(3'd0)) dut (
    .clk(clk), .rst(rst), .num_note(num_note), .rec_start(rec_start),
    .play_start(play_start), .stop(stop), .play_note(play_note),
    .playing(playing), .recording(recording), .full(full),
    .length(length), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] note, input int ticks);
    num_note = note;
    step(TD * ticks);
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1; step(1); rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic play_check(input string name);
    logic [15:0] got_q[$];
    logic [2:0]  cur;
    int cyc, run;
    play_start = 1'b1; step(1); play_start = 1'b0;
    cyc = 0; run = 0; cur = 3'd0;
    while (playing && cyc < 5000) begin
      n_checks++;
      if (recording !== 1'b0) $display("FAIL %s_exclusive: recording=%0b while playing, want 0", name, recording);
      else n_pass++;
      if (run != 0 && play_note !== cur) begin
        got_q.push_back({cur, 13'(run)});
        run = 0;
      end
      cur = play_note; run++; cyc++;
      step(1);
    end
    if (run != 0) got_q.push_back({cur, 13'(run)});
    n_checks++;
    if (cyc >= 5000) $display("FAIL %s_timeout: playing still %0b after %0d cycles, want 0", name, playing, cyc);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL %s_runs: got %0d runs, want %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_run[%0d]: got note=%0d cycles=%0d, want note=%0d cycles=%0d", name, i,
                 got_q[i][15:13], got_q[i][12:0], exp_q[i][15:13], exp_q[i][12:0]);
      else n_pass++;
    end
    n_checks++;
    if (play_note !== 3'd0) $display("FAIL %s_rest: play_note=%0d after playback, want 0", name, play_note);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; num_note = 3'd0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    n_checks += 6;
    if (play_note !== 3'd0) $display("FAIL reset_play_note: got %0d, want 0", play_note); else n_pass++;
    if (length !== 6'd0) $display("FAIL reset_length: got %0d, want 0", length); else n_pass++;
    if (playing !== 1'b0) $display("FAIL reset_playing: got %0b, want 0", playing); else n_pass++;
    if (recording !== 1'b0) $display("FAIL reset_recording: got %0b, want 0", recording); else n_pass++;
    if (full !== 1'b0) $display("FAIL reset_full: got %0b, want 0", full); else n_pass++;
    if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d, want 0", fsm_state); else n_pass++;
  endtask

  task automatic test_simple_take();
    num_note = 3'd1;
    pulse_rec();
    n_checks++;
    if (recording !== 1'b1) $display("FAIL take_recording: got %0b, want 1", recording); else n_pass++;
    hold(3'd1, 3); hold(3'd3, 2); hold(3'd0, 1);
    pulse_stop();
    n_checks += 3;
    if (length !== 6'd3) $display("FAIL take_length: got %0d, want 3", length); else n_pass++;
    if (recording !== 1'b0) $display("FAIL take_stop: recording=%0b, want 0", recording); else n_pass++;
    if (full !== 1'b0) $display("FAIL take_full: got %0b, want 0", full); else n_pass++;
    exp_q.push_back({3'd1, 13'd12});
    exp_q.push_back({3'd3, 13'd8});
    exp_q.push_back({3'd0, 13'd4});
    play_check("take");
  endtask

  task automatic test_saturation();
    num_note = 3'd5;
    pulse_rec();
    hold(3'd5, 300);
    pulse_stop();
    n_checks++;
    if (length !== 6'd2) $display("FAIL sat_length: got %0d, want 2", length); else n_pass++;
    exp_q.push_back({3'd5, 13'd1200});
    play_check("sat");
  endtask

  task automatic test_full_buffer();
    num_note = 3'd1;
    pulse_rec();
    hold(3'd1, 1);
    for (int t = 2; t <= 33; t++) begin
      hold((t % 2 == 0) ? 3'd2 : 3'd1, 1);
      n_checks += 2;
      if (length !== 6'(t - 1)) $display("FAIL full_length_t%0d: got %0d, want %0d", t, length, t - 1); else n_pass++;
      if (recording !== (t < 33)) $display("FAIL full_recording_t%0d: got %0b, want %0b", t, recording, t < 33); else n_pass++;
    end
    n_checks++;
    if (full !== 1'b1) $display("FAIL full_flag: got %0b, want 1", full); else n_pass++;
    hold(3'd2, 1); hold(3'd1, 1);
    n_checks += 2;
    if (length !== 6'd32) $display("FAIL full_stable_length: got %0d, want 32", length); else n_pass++;
    if (full !== 1'b1) $display("FAIL full_stable_flag: got %0b, want 1", full); else n_pass++;
    for (int j = 0; j < 32; j++) exp_q.push_back({(j % 2 == 0) ? 3'd1 : 3'd2, 13'd4});
    play_check("full");
  endtask

  task automatic test_priority();
    num_note = 3'd4;
    pulse_rec();
    hold(3'd4, 2);
    stop = 1'b1; rec_start = 1'b1; step(1); stop = 1'b0; rec_start = 1'b0;
    n_checks += 3;
    if (recording !== 1'b0) $display("FAIL prio_stop_rec: recording=%0b, want 0", recording); else n_pass++;
    if (fsm_state !== 2'd0) $display("FAIL prio_stop_state: got %0d, want 0", fsm_state); else n_pass++;
    if (length !== 6'd1) $display("FAIL prio_flush_length: got %0d, want 1", length); else n_pass++;
    exp_q.push_back({3'd4, 13'd8});
    play_check("prio_flush");
    num_note = 3'd6;
    rec_start = 1'b1; play_start = 1'b1; step(1); rec_start = 1'b0; play_start = 1'b0;
    n_checks += 3;
    if (recording !== 1'b1) $display("FAIL prio_rec_over_play: recording=%0b, want 1", recording); else n_pass++;
    if (playing !== 1'b0) $display("FAIL prio_rec_over_play_pl: playing=%0b, want 0", playing); else n_pass++;
    if (length !== 6'd0) $display("FAIL prio_rec_clear_len: got %0d, want 0", length); else n_pass++;
    play_start = 1'b1; step(1); play_start = 1'b0;
    n_checks += 2;
    if (playing !== 1'b0) $display("FAIL prio_play_in_rec: playing=%0b, want 0", playing); else n_pass++;
    if (recording !== 1'b1) $display("FAIL prio_play_in_rec_rec: recording=%0b, want 1", recording); else n_pass++;
    pulse_stop();
    n_checks += 2;
    if (length !== 6'd0) $display("FAIL prio_empty_stop_len: got %0d, want 0", length); else n_pass++;
    if (recording !== 1'b0) $display("FAIL prio_empty_stop_rec: got %0b, want 0", recording); else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    num_note = 3'd3;
    pulse_rec();
    hold(3'd3, 2);
    pulse_stop();
    play_start = 1'b1; step(1); play_start = 1'b0;
    step(2);
    n_checks += 2;
    if (playing !== 1'b1) $display("FAIL midrst_pre_playing: got %0b, want 1", playing); else n_pass++;
    if (play_note !== 3'd3) $display("FAIL midrst_pre_note: got %0d, want 3", play_note); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (play_note !== 3'd0) $display("FAIL midrst_note: got %0d, want 0", play_note); else n_pass++;
    if (playing !== 1'b0) $display("FAIL midrst_playing: got %0b, want 0", playing); else n_pass++;
    if (length !== 6'd0) $display("FAIL midrst_length: got %0d, want 0", length); else n_pass++;
    if (fsm_state !== 2'd0) $display("FAIL midrst_state: got %0d, want 0", fsm_state); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_play_empty();
    play_start = 1'b1; step(1); play_start = 1'b0;
    n_checks += 3;
    if (playing !== 1'b0) $display("FAIL empty_playing: got %0b, want 0", playing); else n_pass++;
    if (fsm_state !== 2'd0) $display("FAIL empty_state: got %0d, want 0", fsm_state); else n_pass++;
    if (play_note !== 3'd0) $display("FAIL empty_note: got %0d, want 0", play_note); else n_pass++;
    step(8);
    n_checks++;
    if (playing !== 1'b0) $display("FAIL empty_later: playing=%0b, want 0", playing); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_simple_take();
    test_saturation();
    test_full_buffer();
    test_priority();
    test_reset_mid_play();
    test_play_empty();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
